// File: rtl/wb_raxm_master.sv
// rtl/wb_raxm_master.sv - Wishbone master driving an approximate-multiplier register window
// Writes A, B and L, waits out the multiplier pipeline, then reads the product back.
module wb_raxm_master #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          WAIT_CYCLES  = 4,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [15:0] cmd_l,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_p,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [31:0] WAIT_N = 32'(WAIT_CYCLES);
  localparam logic [31:0] TMO_N  = 32'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_L, WAIT, RD_P, RESP} state_t;

  state_t      state_q, state_d;
  logic        gap_q, gap_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] l_q, l_d;
  logic [31:0] p_q, p_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      l_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      l_q     <= l_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  assign rsp_p   = p_q;
  assign rsp_err = err_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    l_d       = l_q;
    p_d       = p_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          l_d     = cmd_l;
          err_d   = 1'b0;
          cnt_d   = '0;
          gap_d   = 1'b0;
          state_d = WR_A;
        end
      end

      WR_A, WR_B, WR_L, RD_P: begin
        if (gap_q) begin
          // Idle bus cycle separating this transfer from the previous one
          gap_d = 1'b0;
          cnt_d = '0;
        end else begin
          wbm_cyc_o = 1'b1;
          wbm_stb_o = 1'b1;
          wbm_sel_o = 4'hF;
          case (state_q)
            WR_A: begin
              wbm_we_o  = 1'b1;
              wbm_adr_o = BASE_ADDRESS;
              wbm_dat_o = {16'h0, a_q};
            end
            WR_B: begin
              wbm_we_o  = 1'b1;
              wbm_adr_o = BASE_ADDRESS + 32'd4;
              wbm_dat_o = {16'h0, b_q};
            end
            WR_L: begin
              wbm_we_o  = 1'b1;
              wbm_adr_o = BASE_ADDRESS + 32'd8;
              wbm_dat_o = {16'h0, l_q};
            end
            default: begin
              wbm_adr_o = BASE_ADDRESS + 32'd12;
            end
          endcase

          if (wbm_ack_i) begin
            cnt_d = '0;
            gap_d = 1'b1;
            case (state_q)
              WR_A:    state_d = WR_B;
              WR_B:    state_d = WR_L;
              WR_L:    state_d = WAIT;
              default: begin
                p_d     = wbm_dat_i;
                state_d = RESP;
              end
            endcase
          end else if (cnt_q + 32'd1 >= TMO_N) begin
            cnt_d   = '0;
            gap_d   = 1'b0;
            p_d     = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end

      WAIT: begin
        if (gap_q) begin
          gap_d = 1'b0;
          cnt_d = '0;
          if (WAIT_N == 32'd0) begin
            state_d = RD_P;
          end
        end else if (cnt_q + 32'd1 >= WAIT_N) begin
          cnt_d   = '0;
          state_d = RD_P;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      RESP: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          rsp_valid = 1'b1;
          if (rsp_ready) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        gap_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_raxm_master.sv
// tb/tb_wb_raxm_master.sv - directed bench for wb_raxm_master
// Includes a Wishbone responder with configurable wait states and a selective no-ack address.
module tb_wb_raxm_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0, cmd_l = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_p;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  wb_raxm_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_l(cmd_l),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          ws = 1;
  bit          noack_en = 1'b0;
  logic [31:0] noack_adr = '0;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  int          gap_err = 0, stab_err = 0, stb_run = 0, last_run = 0, wcnt = 0;
  bit          prev_ack = 1'b0;
  logic [15:0] reg_a = '0, reg_b = '0;
  logic [31:0] h_adr = '0, h_dat = '0;
  logic        h_we = 1'b0;

  // Responder acts on the falling edge so the DUT sees ack/data at the next rising edge
  always @(negedge clk) begin
    logic signed [31:0] sa, sb;
    if (prev_ack && wbm_cyc_o) gap_err++;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    if (!rst && wbm_cyc_o && wbm_stb_o) begin
      if (stb_run == 0) begin
        h_adr = wbm_adr_o; h_dat = wbm_dat_o; h_we = wbm_we_o;
      end else if (h_adr !== wbm_adr_o || h_dat !== wbm_dat_o || h_we !== wbm_we_o) begin
        stab_err++;
      end
      stb_run++;
      if (wcnt >= ws && !(noack_en && wbm_adr_o == noack_adr)) begin
        wbm_ack_i = 1'b1;
        log_adr.push_back(wbm_adr_o);
        log_dat.push_back(wbm_dat_o);
        log_we.push_back(wbm_we_o);
        if (wbm_we_o) begin
          if (wbm_adr_o == BASE)         reg_a = wbm_dat_o[15:0];
          if (wbm_adr_o == BASE + 32'd4) reg_b = wbm_dat_o[15:0];
        end else begin
          sa = {{16{reg_a[15]}}, reg_a};
          sb = {{16{reg_b[15]}}, reg_b};
          wbm_dat_i = sa * sb;
        end
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      if (stb_run != 0) last_run = stb_run;
      stb_run = 0;
      wcnt    = 0;
    end
    prev_ack = wbm_ack_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [15:0] l);
    int n;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_l = l; cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, n;
    logic [31:0] p1, p2;
    logic [31:0] exp_adr[4];
    logic [31:0] exp_dat[4];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc",       {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_stb",       {31'd0, wbm_stb_o}, 32'd0);
    chk("rst_we",        {31'd0, wbm_we_o},  32'd0);
    chk("rst_adr",       wbm_adr_o,          32'd0);
    chk("rst_dat",       wbm_dat_o,          32'd0);
    chk("rst_sel",       {28'd0, wbm_sel_o}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_p",     rsp_p,              32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 3 * 5 with one wait state per ack
    ws = 1;
    clear_log();
    send_cmd(16'd3, 16'd5, 16'hFFFF);
    wait_rsp(lat);
    chk("t1_p",   rsp_p,            32'd15);
    chk("t1_err", {31'd0, rsp_err}, 32'd0);
    ack_rsp();
    chk("t1_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("t1_nxfer", 32'(log_adr.size()), 32'd4);
    exp_adr[0] = 32'h3000_0000; exp_dat[0] = 32'h0000_0003;
    exp_adr[1] = 32'h3000_0004; exp_dat[1] = 32'h0000_0005;
    exp_adr[2] = 32'h3000_0008; exp_dat[2] = 32'h0000_FFFF;
    exp_adr[3] = 32'h3000_000C; exp_dat[3] = 32'h0000_0000;
    for (int i = 0; i < 4 && i < log_adr.size(); i++) begin
      chk($sformatf("t1_adr%0d", i), log_adr[i], exp_adr[i]);
      chk($sformatf("t1_dat%0d", i), log_dat[i], exp_dat[i]);
      chk($sformatf("t1_we%0d", i),  {31'd0, log_we[i]}, (i < 3) ? 32'd1 : 32'd0);
    end

    // Latency with zero-wait acks: 3 writes + 4 wait + 1 read + 4 gaps = 12 cycles, seen at 13th falling edge
    ws = 0;
    send_cmd(16'd1, 16'd1, 16'hFFFF);
    wait_rsp(lat);
    chk("lat_cycles", 32'(lat), 32'd13);
    chk("lat_p", rsp_p, 32'd1);
    ack_rsp();

    // Negative operand, response held while rsp_ready low
    ws = 1;
    send_cmd(16'hFFFE, 16'd7, 16'hFFFF);
    wait_rsp(lat);
    repeat (5) @(negedge clk);
    chk("t2_valid_held", {31'd0, rsp_valid}, 32'd1);
    chk("t2_p",          rsp_p,              32'hFFFF_FFF2);
    chk("t2_err",        {31'd0, rsp_err},   32'd0);
    ack_rsp();
    chk("t2_valid_drop", {31'd0, rsp_valid}, 32'd0);

    // B write never acked: timeout after 255 strobe cycles
    clear_log();
    noack_en  = 1'b1;
    noack_adr = BASE + 32'd4;
    send_cmd(16'd9, 16'd9, 16'hFFFF);
    wait_rsp(lat);
    chk("t3_err", {31'd0, rsp_err}, 32'd1);
    chk("t3_p",   rsp_p,            32'd0);
    ack_rsp();
    chk("t3_stb_len", 32'(last_run), 32'd255);
    repeat (5) @(negedge clk);
    chk("t3_nxfer", 32'(log_adr.size()), 32'd1);
    chk("t3_cyc",   {31'd0, wbm_cyc_o},  32'd0);
    noack_en = 1'b0;

    // Three wait states per ack: stable bus, four transfers, gaps between them
    ws = 3;
    clear_log();
    stab_err = 0;
    gap_err  = 0;
    send_cmd(16'h1234, 16'h0010, 16'hFFFF);
    chk("t4_err_cleared", {31'd0, rsp_err}, 32'd0);
    wait_rsp(lat);
    chk("t4_p", rsp_p, 32'h0001_2340);
    ack_rsp();
    chk("t4_stable",  32'(stab_err),       32'd0);
    chk("t4_gaps",    32'(gap_err),        32'd0);
    chk("t4_nxfer",   32'(log_adr.size()), 32'd4);
    chk("t4_stb_len", 32'(last_run),       32'd4);

    // Reset asserted while the L write is on the bus
    ws = 1;
    send_cmd(16'd5, 16'd5, 16'hFFFF);
    n = 0;
    while (!(wbm_stb_o && wbm_adr_o == BASE + 32'd8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_wr_l", wbm_adr_o, BASE + 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_cyc",   {31'd0, wbm_cyc_o}, 32'd0);
    chk("t5_rst_stb",   {31'd0, wbm_stb_o}, 32'd0);
    chk("t5_rst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t5_idle_cyc",   {31'd0, wbm_cyc_o}, 32'd0);
    clear_log();
    send_cmd(16'd2, 16'd9, 16'hFFFF);
    wait_rsp(lat);
    chk("t5_p",   rsp_p,            32'd18);
    chk("t5_err", {31'd0, rsp_err}, 32'd0);
    ack_rsp();
    chk("t5_nxfer", 32'(log_adr.size()), 32'd4);

    // Back-to-back commands with cmd_valid and rsp_ready held high
    ws = 0;
    clear_log();
    gap_err   = 0;
    rsp_ready = 1'b1;
    cmd_a = 16'd4; cmd_b = 16'd6; cmd_l = 16'hFFFF;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_a = 16'hFFFF; cmd_b = 16'hFFFF;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    p1 = rsp_p;
    chk("t6_no_overlap", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t6_second_accept", {31'd0, cmd_ready}, 32'd1);
    chk("t6_valid_low",     {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_busy", {31'd0, cmd_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    p2 = rsp_p;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t6_p1",    p1, 32'd24);
    chk("t6_p2",    p2, 32'd1);
    chk("t6_nxfer", 32'(log_adr.size()), 32'd8);
    chk("t6_gaps",  32'(gap_err),        32'd0);
    if (log_adr.size() > 4) chk("t6_second_a_adr", log_adr[4], BASE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
